weight_mem_arbiter: RTL and testbench

Arbitrates the single synchronous-read weight/bias memory port between two burst requesters: the CNN engine's weight fetcher and the FC block's DMA. Each requester posts a burst (start address, word count); the block grants one requester at a time, round-robin, and issues sequential addresses on `mem_addr`. It returns read words tagged with a per-requester valid strobe and signals burst completion with a done pulse. It sits between both engines and the memory, replacing the direct DMA-to-memory address connection.

---
 rtl/fc_pkg.sv | 32 +++
 rtl/weight_mem_arbiter_if.sv | 49 ++++
 rtl/rr_arbiter_2.sv | 29 ++
 rtl/weight_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_weight_mem_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared types and default widths for the weight/bias memory arbiter and the
// blocks that talk to it.
//   mem_req_e    : requester identity (CNN weight fetcher / FC DMA)
//   arb_state_e  : arbiter FSM states
//   *_DEF        : default word / address / burst-count widths
// -----------------------------------------------------------------------------
package fc_pkg;

  localparam int WORD_SIZE_DEF         = 16;
  localparam int MEM_ADDRESS_WIDTH_DEF = 10;
  localparam int COUNT_WIDTH_DEF       = 8;
  localparam int NUM_REQ               = 2;

  typedef enum logic {
    REQ_CNN = 1'b0,
    REQ_FC  = 1'b1
  } mem_req_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // The requester that is not r; used to break ties in round-robin order.
  function automatic mem_req_e other_req(input mem_req_e r);
    return (r == REQ_CNN) ? REQ_FC : REQ_CNN;
  endfunction

endpackage

// File: rtl/weight_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// weight_mem_arbiter_if
// Bundles the two requester burst handshakes and the memory read port seen by
// weight_mem_arbiter.
//   Requester side : req_*, addr_*, count_* (in to arbiter)
//                    gnt_*, rd_valid_*, rd_last, rd_data, done_* (out)
//   Memory side    : mem_addr (out of arbiter), mem_data (in, 1-cycle latency)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + memory) driving the arbiter
// -----------------------------------------------------------------------------
interface weight_mem_arbiter_if
  import fc_pkg::*;
#(
  parameter int WORD_SIZE         = WORD_SIZE_DEF,
  parameter int MEM_ADDRESS_WIDTH = MEM_ADDRESS_WIDTH_DEF,
  parameter int COUNT_WIDTH       = COUNT_WIDTH_DEF
);

  logic                         req_cnn;
  logic                         req_fc;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_cnn;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_fc;
  logic [COUNT_WIDTH-1:0]       count_cnn;
  logic [COUNT_WIDTH-1:0]       count_fc;
  logic                         gnt_cnn;
  logic                         gnt_fc;
  logic [MEM_ADDRESS_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]         mem_data;
  logic [WORD_SIZE-1:0]         rd_data;
  logic                         rd_valid_cnn;
  logic                         rd_valid_fc;
  logic                         rd_last;
  logic                         done_cnn;
  logic                         done_fc;

  modport slave (
    input  req_cnn, req_fc, addr_cnn, addr_fc, count_cnn, count_fc, mem_data,
    output gnt_cnn, gnt_fc, mem_addr, rd_data, rd_valid_cnn, rd_valid_fc,
           rd_last, done_cnn, done_fc
  );

  modport master (
    output req_cnn, req_fc, addr_cnn, addr_fc, count_cnn, count_fc, mem_data,
    input  gnt_cnn, gnt_fc, mem_addr, rd_data, rd_valid_cnn, rd_valid_fc,
           rd_last, done_cnn, done_fc
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Combinational two-way round-robin winner select.
//   req         in  2  {req_fc, req_cnn}
//   last_served in  1  requester granted most recently
//   grant_valid out 1  at least one request present
//   winner      out 1  selected requester (meaningful only with grant_valid)
// On a tie the requester that was not served last wins.
// -----------------------------------------------------------------------------
module rr_arbiter_2
  import fc_pkg::*;
(
  input  logic [1:0] req,
  input  mem_req_e   last_served,
  output logic       grant_valid,
  output mem_req_e   winner
);

  always_comb begin
    grant_valid = |req;
    winner      = REQ_CNN;
    if (req == 2'b11) begin
      winner = other_req(last_served);
    end else if (req[1]) begin
      winner = REQ_FC;
    end
  end

endmodule

// File: rtl/weight_mem_arbiter.sv
// -----------------------------------------------------------------------------
// weight_mem_arbiter
// Shares one synchronous-read weight/bias memory port between the CNN weight
// fetcher and the FC DMA. A granted burst issues one sequential address per
// cycle; returned words are tagged with a per-requester valid, the final word
// with rd_last, and the burst ends with a one-cycle done pulse.
//   clk  in  1   rising-edge clock
//   rst  in  1   asynchronous, active-low reset
//   bus  slave modport of weight_mem_arbiter_if (requesters + memory port)
// FSM: IDLE (arbitrate/latch) -> ISSUE (N addresses) -> DRAIN (last word,
// done) -> IDLE. A zero-length burst goes IDLE -> DRAIN -> IDLE.
// -----------------------------------------------------------------------------
module weight_mem_arbiter
  import fc_pkg::*;
#(
  parameter int WORD_SIZE         = WORD_SIZE_DEF,
  parameter int MEM_ADDRESS_WIDTH = MEM_ADDRESS_WIDTH_DEF,
  parameter int COUNT_WIDTH       = COUNT_WIDTH_DEF
)(
  input  logic                 clk,
  input  logic                 rst,
  weight_mem_arbiter_if.slave  bus
);

  arb_state_e                   state_reg, state_next;
  logic [MEM_ADDRESS_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [COUNT_WIDTH-1:0]       remaining_reg, remaining_next;
  mem_req_e                     owner_reg, owner_next;
  mem_req_e                     last_served_reg, last_served_next;
  logic                         issued_reg, issued_next;

  logic                         grant_valid;
  mem_req_e                     winner;
  logic [MEM_ADDRESS_WIDTH-1:0] sample_addr;
  logic [COUNT_WIDTH-1:0]       sample_count;

  logic [NUM_REQ-1:0]           gnt_vec;
  logic [NUM_REQ-1:0]           rd_valid_vec;
  logic [NUM_REQ-1:0]           done_vec;
  logic [WORD_SIZE-1:0]         rd_word;

  rr_arbiter_2 u_rr_arbiter_2 (
    .req         ({bus.req_fc, bus.req_cnn}),
    .last_served (last_served_reg),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  assign sample_addr  = (winner == REQ_CNN) ? bus.addr_cnn  : bus.addr_fc;
  assign sample_count = (winner == REQ_CNN) ? bus.count_cnn : bus.count_fc;

  // Next-state and datapath update.
  always_comb begin
    state_next       = state_reg;
    mem_addr_next    = mem_addr_reg;
    remaining_next   = remaining_reg;
    owner_next       = owner_reg;
    last_served_next = last_served_reg;
    issued_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Requests are only looked at here; a burst is never aborted.
        if (grant_valid) begin
          owner_next       = winner;
          last_served_next = winner;
          mem_addr_next    = sample_addr;
          remaining_next   = sample_count;
          state_next       = (sample_count == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        // mem_addr_reg is on the bus this cycle; its data returns next cycle.
        issued_next    = 1'b1;
        remaining_next = remaining_reg - 1'b1;
        if (remaining_reg == COUNT_WIDTH'(1)) begin
          // Final address stays on mem_addr through DRAIN and IDLE.
          state_next = DRAIN;
        end else begin
          mem_addr_next = mem_addr_reg + 1'b1;  // wraps modulo 2^width
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      mem_addr_reg    <= '0;
      remaining_reg   <= '0;
      owner_reg       <= REQ_CNN;
      last_served_reg <= REQ_FC;  // CNN wins the first tie after reset
      issued_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mem_addr_reg    <= mem_addr_next;
      remaining_reg   <= remaining_next;
      owner_reg       <= owner_next;
      last_served_reg <= last_served_next;
      issued_reg      <= issued_next;
    end
  end

  // Grant is held for the whole burst, i.e. whenever the FSM is not IDLE.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign gnt_vec[gi]      = (state_reg != IDLE) && (int'(owner_reg) == gi);
    assign rd_valid_vec[gi] = gnt_vec[gi] && issued_reg;
    assign done_vec[gi]     = gnt_vec[gi] && (state_reg == DRAIN);
  end

  assign rd_word          = bus.mem_data;
  assign bus.rd_data      = rd_word;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.gnt_cnn      = gnt_vec[REQ_CNN];
  assign bus.gnt_fc       = gnt_vec[REQ_FC];
  assign bus.rd_valid_cnn = rd_valid_vec[REQ_CNN];
  assign bus.rd_valid_fc  = rd_valid_vec[REQ_FC];
  assign bus.done_cnn     = done_vec[REQ_CNN];
  assign bus.done_fc      = done_vec[REQ_FC];
  // The word returning in DRAIN is the last one; zero-length bursts never
  // set issued_reg, so they produce no rd_last.
  assign bus.rd_last      = issued_reg && (state_reg == DRAIN);

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_weight_mem_arbiter
// Directed bench for weight_mem_arbiter: single bursts, round-robin ties,
// address wrap, zero-length burst, mid-burst req drop, a request waiting on
// another burst, and asynchronous reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_weight_mem_arbiter;
  import fc_pkg::*;

  // Output flag vector: {gnt_cnn, gnt_fc, rd_valid_cnn, rd_valid_fc,
  //                      rd_last, done_cnn, done_fc}
  localparam logic [6:0] F_IDLE = 7'b0000000;
  localparam logic [6:0] G_C    = 7'b1000000;
  localparam logic [6:0] V_C    = 7'b1010000;
  localparam logic [6:0] D_C    = 7'b1010110;
  localparam logic [6:0] Z_C    = 7'b1000010;
  localparam logic [6:0] G_F    = 7'b0100000;
  localparam logic [6:0] V_F    = 7'b0101000;
  localparam logic [6:0] D_F    = 7'b0101101;
  localparam logic [6:0] Z_F    = 7'b0100001;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [15:0] mem [0:1023];

  always #5 clk = ~clk;

  weight_mem_arbiter_if bus ();

  weight_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read memory model: data one cycle after the address.
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp_f, input logic [9:0] exp_a);
    logic [6:0] obs;
    obs = {bus.gnt_cnn, bus.gnt_fc, bus.rd_valid_cnn, bus.rd_valid_fc,
           bus.rd_last, bus.done_cnn, bus.done_fc};
    vectors++;
    assert (obs === exp_f) else begin
      miscompares++;
      $error("FAIL %s flags: observed %b expected %b", tag, obs, exp_f);
    end
    vectors++;
    assert (bus.mem_addr === exp_a) else begin
      miscompares++;
      $error("FAIL %s mem_addr: observed %h expected %h", tag, bus.mem_addr, exp_a);
    end
  endtask

  task automatic chk_data(input string tag, input logic [15:0] exp_d);
    vectors++;
    assert (bus.rd_data === exp_d) else begin
      miscompares++;
      $error("FAIL %s rd_data: observed %h expected %h", tag, bus.rd_data, exp_d);
    end
  endtask

  // Called in the IDLE cycle where the request is already presented; checks
  // every cycle of an n-word burst from grant through the following IDLE.
  task automatic burst(input string tag, input bit fc, input logic [9:0] a,
                       input int n, input bit drop_early);
    logic [9:0] ea;
    logic [9:0] da;
    step();
    if (drop_early) begin
      if (fc) bus.req_fc = 1'b0;
      else    bus.req_cnn = 1'b0;
    end
    if (n == 0) begin
      chk($sformatf("%s_g", tag), fc ? Z_F : Z_C, a);
    end else begin
      chk($sformatf("%s_g", tag), fc ? G_F : G_C, a);
      for (int k = 1; k <= n; k++) begin
        step();
        ea = (k < n) ? a + 10'(k) : a + 10'(n - 1);
        da = a + 10'(k - 1);
        chk($sformatf("%s_c%0d", tag, k),
            (k < n) ? (fc ? V_F : V_C) : (fc ? D_F : D_C), ea);
        chk_data($sformatf("%s_d%0d", tag, k), mem[da]);
      end
    end
    step();
    ea = (n == 0) ? a : a + 10'(n - 1);
    chk($sformatf("%s_idle", tag), F_IDLE, ea);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hC000 ^ 16'(i * 37);
    rst           = 1'b0;
    bus.req_cnn   = 1'b0;
    bus.req_fc    = 1'b0;
    bus.addr_cnn  = '0;
    bus.addr_fc   = '0;
    bus.count_cnn = '0;
    bus.count_fc  = '0;
    step();
    step();
    chk("reset", F_IDLE, 10'h000);

    // Single CNN burst straight out of reset.
    rst = 1'b1;
    bus.req_cnn = 1'b1; bus.addr_cnn = 10'h010; bus.count_cnn = 8'd3;
    chk("t1_c0", F_IDLE, 10'h000);
    burst("t1", 1'b0, 10'h010, 3, 1'b0);
    bus.req_cnn = 1'b0;

    // Zero-length FC burst: grant and done together, no valids.
    bus.req_fc = 1'b1; bus.addr_fc = 10'h155; bus.count_fc = 8'd0;
    burst("zero", 1'b1, 10'h155, 0, 1'b0);

    // Both requesting, three times: CNN, FC, CNN with one IDLE between.
    bus.req_cnn = 1'b1; bus.addr_cnn = 10'h020; bus.count_cnn = 8'd2;
    bus.req_fc  = 1'b1; bus.addr_fc  = 10'h040; bus.count_fc  = 8'd2;
    burst("rr1", 1'b0, 10'h020, 2, 1'b0);
    bus.addr_cnn = 10'h030;
    burst("rr2", 1'b1, 10'h040, 2, 1'b0);
    burst("rr3", 1'b0, 10'h030, 2, 1'b0);

    // FC burst wrapping past the top of the address space.
    bus.req_cnn = 1'b0;
    bus.addr_fc = 10'h3FE; bus.count_fc = 8'd4;
    burst("wrap", 1'b1, 10'h3FE, 4, 1'b0);
    bus.req_fc = 1'b0;

    // CNN drops req right after grant; burst still completes.
    bus.req_cnn = 1'b1; bus.addr_cnn = 10'h100; bus.count_cnn = 8'd5;
    burst("drop", 1'b0, 10'h100, 5, 1'b1);

    // CNN raises req during an FC burst and waits for the IDLE cycle.
    bus.req_fc = 1'b1; bus.addr_fc = 10'h200; bus.count_fc = 8'd2;
    step();
    chk("wait_fc_g", G_F, 10'h200);
    bus.req_fc = 1'b0;
    bus.req_cnn = 1'b1; bus.addr_cnn = 10'h050; bus.count_cnn = 8'd1;
    step();
    chk("wait_fc_c1", V_F, 10'h201);
    step();
    chk("wait_fc_c2", D_F, 10'h201);
    step();
    chk("wait_fc_idle", F_IDLE, 10'h201);
    burst("wait_cnn", 1'b0, 10'h050, 1, 1'b0);

    // Asynchronous reset in cycle 2 of an 8-word CNN burst.
    bus.addr_cnn = 10'h080; bus.count_cnn = 8'd8;
    step();
    chk("rst_b_g", G_C, 10'h080);
    step();
    chk("rst_b_c1", V_C, 10'h081);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", F_IDLE, 10'h000);
    step();
    chk("rst_hold", F_IDLE, 10'h000);
    rst = 1'b1;
    bus.req_cnn = 1'b1; bus.addr_cnn = 10'h0A0; bus.count_cnn = 8'd1;
    bus.req_fc  = 1'b1; bus.addr_fc  = 10'h0B0; bus.count_fc  = 8'd1;
    chk("rst_rel", F_IDLE, 10'h000);
    burst("post_cnn", 1'b0, 10'h0A0, 1, 1'b0);
    bus.req_cnn = 1'b0;
    burst("post_fc", 1'b1, 10'h0B0, 1, 1'b0);
    bus.req_fc = 1'b0;
    step();
    chk("final_idle", F_IDLE, 10'h0B0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
